// File: rtl/rect_ctl_if.sv
// rect_ctl_if
//   Position-request channel between an upstream source (mouse or keyboard
//   decoder) and rect_ctl.
//
//   Handshake: a request transfers on a rising pclk edge where req_valid and
//   req_ready are both high. The source keeps req_x/req_y/req_fall stable
//   while req_valid is high and not yet accepted. The sink may hold req_ready
//   low for any number of cycles; request fields are ignored while it is low.
//
//   Signals:
//     req_valid  source -> sink  a request is present
//     req_ready  sink -> source  the sink accepts a request this cycle
//     req_x      source -> sink  requested top-left x (12 bits)
//     req_y      source -> sink  requested top-left y (12 bits)
//     req_fall   source -> sink  enter drop mode once this request is committed
interface rect_ctl_if;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_x;
    logic [11:0] req_y;
    logic        req_fall;

    modport master (
        output req_valid,
        output req_x,
        output req_y,
        output req_fall,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_x,
        input  req_y,
        input  req_fall,
        output req_ready
    );
endinterface

// File: rtl/rect_ctl.sv
// rect_ctl
//   Frame-synchronous position controller for the rectangle overlay. A
//   request is clamped and parked when accepted, then committed to xpos/ypos
//   only on the first frame tick (start of vertical blanking) that follows, so
//   draw_rect never sees a position change mid-frame. In drop mode ypos moves
//   down by STEP on every frame tick until the rectangle touches the bottom.
//
//   Ports:
//     pclk        pixel clock, rising edge
//     rst         synchronous active-low reset
//     vblnk_in    vertical blanking from vga_timing
//     req         request channel (rect_ctl_if.slave)
//     xpos, ypos  committed top-left position to draw_rect
//     frame_tick  registered one-cycle pulse per rising edge of vblnk_in
//     busy        high whenever the controller is not IDLE
//     state_dbg   current FSM state (0 IDLE, 1 PEND, 2 FALL)
module rect_ctl #(
    parameter int XMAX   = 800,
    parameter int YMAX   = 600,
    parameter int RECT_W = 48,
    parameter int RECT_H = 64,
    parameter int STEP   = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    rect_ctl_if.slave   req,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        frame_tick,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Largest legal top-left coordinates; 13 bits so that a 12-bit request
    // or ypos+STEP can be compared without wrapping.
    localparam logic [12:0] X_LIM   = 13'(XMAX - RECT_W);
    localparam logic [12:0] Y_LIM   = 13'(YMAX - RECT_H);
    localparam logic [11:0] X_LIM12 = 12'(XMAX - RECT_W);
    localparam logic [11:0] Y_LIM12 = 12'(YMAX - RECT_H);
    localparam logic [12:0] STEP13  = 13'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        FALL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        vblnk_d;
    logic [11:0] pend_x;
    logic [11:0] pend_y;
    logic        pend_fall;

    logic        accept;
    logic [11:0] x_c;
    logic [11:0] y_c;
    logic [12:0] y_step;
    logic [11:0] y_fall;

    logic        ready_nxt;
    logic        busy_nxt;
    logic [11:0] xpos_nxt;
    logic [11:0] ypos_nxt;

    assign accept    = req.req_valid & req.req_ready;
    assign state_dbg = state;

    // Clamp at capture time so the pending registers only ever hold legal values.
    assign x_c = ({1'b0, req.req_x} > X_LIM) ? X_LIM12 : req.req_x;
    assign y_c = ({1'b0, req.req_y} > Y_LIM) ? Y_LIM12 : req.req_y;

    // Drop-mode step, saturating at the bottom edge.
    assign y_step = {1'b0, ypos} + STEP13;
    assign y_fall = (y_step > Y_LIM) ? Y_LIM12 : y_step[11:0];

    // State register
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A handshake coinciding with frame_tick only parks the
                // request; it commits on the following tick.
                if (accept) state_nxt = PEND;
            end
            PEND: begin
                if (frame_tick) begin
                    if (pend_fall && ({1'b0, pend_y} < Y_LIM)) state_nxt = FALL;
                    else                                        state_nxt = IDLE;
                end
            end
            FALL: begin
                if (frame_tick && ({1'b0, y_fall} == Y_LIM)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        xpos_nxt  = xpos;
        ypos_nxt  = ypos;
        if (frame_tick) begin
            if (state == PEND) begin
                xpos_nxt = pend_x;
                ypos_nxt = pend_y;
            end else if (state == FALL) begin
                ypos_nxt = y_fall;
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge pclk) begin
        if (!rst) begin
            // vblnk_d starts high so releasing reset inside blanking
            // does not look like a new frame.
            vblnk_d       <= 1'b1;
            frame_tick    <= 1'b0;
            req.req_ready <= 1'b0;
            busy          <= 1'b0;
            xpos          <= 12'd0;
            ypos          <= 12'd0;
            pend_x        <= 12'd0;
            pend_y        <= 12'd0;
            pend_fall     <= 1'b0;
        end else begin
            vblnk_d       <= vblnk_in;
            frame_tick    <= vblnk_in & ~vblnk_d;
            req.req_ready <= ready_nxt;
            busy          <= busy_nxt;
            xpos          <= xpos_nxt;
            ypos          <= ypos_nxt;
            if (state == IDLE && accept) begin
                pend_x    <= x_c;
                pend_y    <= y_c;
                pend_fall <= req.req_fall;
            end
        end
    end

endmodule
